avalon_pixel_writer: RTL
========================

AVALON_PIXEL_WRITER -- requirements
Module: avalon_pixel_writer

Interface
REQ-001 Param X_END, default 3, last column index; the image is X_END+1 pixels wide.
REQ-002 Param Y_END, default 3, last row index; the image is Y_END+1 rows high.
REQ-003 Param CW, default 3, width of the X and Y coordinate counters; must hold X_END and Y_END.
REQ-004 Param DATA_W, default 8, pixel and writedata width.
REQ-005 Param ADDR_W, default 16, Avalon address width.
REQ-006 Param BASE_ADDR, default 0, Avalon address of pixel (0,0).
REQ-007 clk_i  in  1  single clock; all logic is rising-edge.
REQ-008 rst_i  in  1  reset, asynchronous and active-high.
REQ-009 start_i  in  1  begin a frame; honoured only in IDLE.
REQ-010 clear_i  in  1  synchronous abort back to IDLE.
REQ-011 pixel_i  in  DATA_W  processed pixel from the filter.
REQ-012 pixel_valid_i  in  1  pixel_i is valid.
REQ-013 pixel_ready_o  out  1  the block accepts pixel_i this cycle.
REQ-014 avm_address_o  out  ADDR_W  Avalon-MM write address.
REQ-015 avm_write_o  out  1  Avalon-MM write request.
REQ-016 avm_writedata_o  out  DATA_W  Avalon-MM write data.
REQ-017 avm_waitrequest_i  in  1  slave stall.
REQ-018 X_o  out  CW  column of the pixel in flight or expected next.
REQ-019 Y_o  out  CW  row of the pixel in flight or expected next.
REQ-020 busy_o  out  1  high in every state except IDLE.
REQ-021 done_o  out  1  one-cycle pulse after the last write is accepted.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, WAIT_PIX, WRITE, DONE.
REQ-023 IDLE: pixel_ready_o=0 and avm_write_o=0; on start_i, X and Y SHALL clear to 0 and the FSM SHALL enter WAIT_PIX.
REQ-024 WAIT_PIX: pixel_ready_o=1; on pixel_valid_i the block SHALL perform these actions, effective next cycle:
- register pixel_i into avm_writedata_o;
- register BASE_ADDR + Y*(X_END+1) + X into avm_address_o, truncated to ADDR_W;
- enter WRITE.
REQ-025 WRITE: avm_write_o=1 and pixel_ready_o=0; address and data SHALL stay stable while avm_waitrequest_i=1.
REQ-026 The write is accepted in the WRITE cycle where avm_waitrequest_i=0; avm_write_o SHALL deassert the following cycle.
REQ-027 On acceptance with X<X_END, X SHALL increment by 1 and the FSM SHALL return to WAIT_PIX.
REQ-028 On acceptance with X=X_END and Y<Y_END, X SHALL become 0, Y SHALL increment by 1, and the FSM SHALL return to WAIT_PIX.
REQ-029 On acceptance with X=X_END and Y=Y_END, X and Y SHALL hold and the FSM SHALL enter DONE.
REQ-030 DONE SHALL assert done_o for exactly one cycle, then return to IDLE with X and Y cleared to 0.
REQ-031 Throughput SHALL be at most one pixel per 2 cycles; each waitrequest cycle adds one cycle.
REQ-032 start_i SHALL be ignored in WAIT_PIX, WRITE and DONE.
REQ-033 clear_i in WAIT_PIX or DONE SHALL force the next state to IDLE with X=Y=0; clear_i in DONE SHALL NOT suppress that cycle's done_o.
REQ-034 clear_i in WRITE SHALL be recorded and applied only once the write is accepted; avm_write_o SHALL never drop while avm_waitrequest_i=1.
REQ-035 A recorded clear SHALL send the FSM to IDLE with no done_o pulse, even when the accepted write was the last pixel.
REQ-036 clear_i and start_i together in IDLE: clear_i SHALL win and the FSM SHALL stay in IDLE.
REQ-037 Pixels presented outside WAIT_PIX SHALL NOT be consumed.

Reset
REQ-038 While rst_i=1, regardless of clock, the FSM SHALL be IDLE and the following SHALL be 0:
- X_o, Y_o;
- avm_address_o, avm_writedata_o;
- avm_write_o, pixel_ready_o, busy_o, done_o;
- any pending clear.
REQ-039 Reset asserted in WRITE SHALL drop avm_write_o immediately; after reset deasserts, a new start_i SHALL be required.

Verification
REQ-040 The bench SHALL cover these directed scenarios (defaults: X_END=3, Y_END=3):
- Full frame: start_i, 16 pixels 0x10..0x1F, waitrequest=0 -> addresses 0..15 carry data 0x10..0x1F; done_o pulses once 2 cycles after the 16th valid; busy_o falls with it.
- Row wrap: after the 4th accepted write -> X_o=0, Y_o=1; the next address is 4.
- Waitrequest: waitrequest held 3 cycles on pixel (2,1) -> address 6 and data stable for 4 cycles with avm_write_o=1; pixel_ready_o=0 throughout.
- Clear during stalled write: clear_i in WRITE while waitrequest=1 -> the write completes when waitrequest drops, then IDLE with X=Y=0 and no done_o.
- Async reset mid-frame: rst_i pulsed between clock edges during WRITE -> all outputs 0 before the next edge; start_i ignored until rst_i drops.
- BASE_ADDR=0x100: full frame -> addresses 0x100..0x10F; pixel_valid_i held high with no start_i -> no write issued.

Source files
------------

// File: rtl/avalon_pixel_writer.sv
// Avalon-MM pixel writer: stores a stream of filtered pixels
// into a raster frame buffer, one Avalon write per pixel.
module avalon_pixel_writer #(
    parameter int X_END     = 3,
    parameter int Y_END     = 3,
    parameter int CW        = 3,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    output logic              pixel_ready_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_write_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    input  logic              avm_waitrequest_i,
    output logic [CW-1:0]     X_o,
    output logic [CW-1:0]     Y_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PIX,
        WRITE,
        DONE
    } state_t;

    localparam logic [CW-1:0]     X_LAST  = CW'(X_END);
    localparam logic [CW-1:0]     Y_LAST  = CW'(Y_END);
    localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(X_END + 1);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              clr_q, clr_d;
    logic [ADDR_W-1:0] pix_addr;

    // Raster address of the pixel at the current (X, Y).
    assign pix_addr = BASE + ADDR_W'(y_q) * ROW_LEN + ADDR_W'(x_q);

    // Next-state, coordinate and write-beat logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        data_d  = data_q;
        clr_d   = clr_q;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    x_d = '0;
                    y_d = '0;
                end else if (start_i) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = WAIT_PIX;
                end
            end
            WAIT_PIX: begin
                if (clear_i) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = IDLE;
                end else if (pixel_valid_i) begin
                    data_d  = pixel_i;
                    addr_d  = pix_addr;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A clear cannot cut a pending write short; hold it.
                if (clear_i) clr_d = 1'b1;
                if (!avm_waitrequest_i) begin
                    if (clr_q || clear_i) begin
                        x_d     = '0;
                        y_d     = '0;
                        clr_d   = 1'b0;
                        state_d = IDLE;
                    end else if (x_q != X_LAST) begin
                        x_d     = x_q + CW'(1);
                        state_d = WAIT_PIX;
                    end else if (y_q != Y_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + CW'(1);
                        state_d = WAIT_PIX;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                x_d     = '0;
                y_d     = '0;
                clr_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state so reset clears them at once.
    always_comb begin
        pixel_ready_o   = (state_q == WAIT_PIX);
        avm_write_o     = (state_q == WRITE);
        busy_o          = (state_q != IDLE);
        done_o          = (state_q == DONE);
        avm_address_o   = addr_q;
        avm_writedata_o = data_q;
        X_o             = x_q;
        Y_o             = y_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            clr_q   <= clr_d;
        end
    end

endmodule
